// File: rtl/prog_loader.sv
// Program loader: streams an instruction segment then a data segment into the
// processor's external memory ports, then enables the CPU for a bounded run.
module prog_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int RUN_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        s_last,
    input  logic        halt,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS) + 1;
    localparam int CNT_W     = $clog2(RUN_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               overflow;
    logic               seg_end;

    assign accept    = s_valid & s_ready;
    assign ren_ext   = 1'b0;
    assign ren_ext_2 = 1'b0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        overflow   = 1'b0;
        seg_end    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = LOAD_I;
            end
            LOAD_I: begin
                if (accept) begin
                    overflow = !s_last && (idx == IDX_W'(IMEM_WORDS - 1));
                    seg_end  = s_last || overflow;
                    if (seg_end) state_next = LOAD_D;
                end
            end
            LOAD_D: begin
                if (accept) begin
                    overflow = !s_last && (idx == IDX_W'(DMEM_WORDS - 1));
                    seg_end  = s_last || overflow;
                    if (seg_end) state_next = RUN;
                end
            end
            RUN: begin
                if (halt || (cnt == CNT_W'(RUN_CYCLES - 1))) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Status flags are derived from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_ready     <= 1'b0;
            cpu_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            wen_ext     <= 1'b0;
            wen_ext_2   <= 1'b0;
            addr_ext    <= '0;
            addr_ext_2  <= '0;
            wdata_ext   <= '0;
            wdata_ext_2 <= '0;
            idx         <= '0;
            cnt         <= '0;
        end else begin
            s_ready    <= (state_next == LOAD_I) || (state_next == LOAD_D);
            cpu_enable <= (state_next == RUN);
            busy       <= (state_next != IDLE) && (state_next != DONE);
            done       <= (state_next == DONE);
            wen_ext    <= 1'b0;
            wen_ext_2  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx <= '0;
                        cnt <= '0;
                        err <= 1'b0;
                    end
                end
                LOAD_I: begin
                    if (accept) begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= 64'({idx, 2'b00});
                        wdata_ext <= s_data[31:0];
                        idx       <= seg_end ? '0 : idx + IDX_W'(1);
                        if (overflow) err <= 1'b1;
                    end
                end
                LOAD_D: begin
                    if (accept) begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= 64'({idx, 3'b000});
                        wdata_ext_2 <= s_data;
                        idx         <= seg_end ? '0 : idx + IDX_W'(1);
                        if (overflow) err <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
